// File: rtl/xmodem_rx_ctrl_if.sv
// rtl/xmodem_rx_ctrl_if.sv - byte-stream, response and scene-memory write signals of the XMODEM receiver
interface xmodem_rx_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid, wr_addr, wr_data, wr_en
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid, wr_addr, wr_data, wr_en
    );
endinterface

// File: rtl/xmodem_rx_ctrl.sv
// rtl/xmodem_rx_ctrl.sv - XMODEM (checksum) receiver writing payload to scene memory
module xmodem_rx_ctrl #(
    parameter int BLOCK_BYTES = 128,
    parameter int ADDR_W      = 15,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    xmodem_rx_ctrl_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   num_bytes,
    output logic [7:0]        nak_count
);
    localparam int IDX_W = $clog2(BLOCK_BYTES);

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [3:0] IDLE           = 4'd0;
    localparam logic [3:0] SEND_START_NAK = 4'd1;
    localparam logic [3:0] WAIT_SOH       = 4'd2;
    localparam logic [3:0] BLK            = 4'd3;
    localparam logic [3:0] BLK_INV        = 4'd4;
    localparam logic [3:0] DATA           = 4'd5;
    localparam logic [3:0] CSUM           = 4'd6;
    localparam logic [3:0] RESP           = 4'd7;
    localparam logic [3:0] DONE           = 4'd8;

    logic [3:0]        state;
    logic [7:0]        expected;
    logic [7:0]        blk;
    logic [7:0]        csum;
    logic [IDX_W-1:0]  idx;
    logic              hdr_ok;
    logic              dup;
    logic              eot;
    logic [ADDR_W-1:0] blk_acc;
    logic [31:0]       tcnt;

    logic              timed;
    logic              tmo;
    logic              hs;
    logic [ADDR_W-1:0] blk_sel;

    assign timed        = (state == BLK) || (state == BLK_INV) || (state == DATA) || (state == CSUM);
    assign tmo          = timed && !bus.rx_valid && (tcnt == 32'(TIMEOUT_CYC - 1));
    assign bus.tx_valid = (state == SEND_START_NAK) || (state == RESP);
    assign hs           = bus.tx_valid && bus.tx_ready;
    assign busy         = (state != IDLE) && (state != DONE);
    assign done         = (state == DONE);
    // A duplicate block rewrites the slot of the last accepted block
    assign blk_sel      = dup ? blk_acc - 1'b1 : blk_acc;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            bus.tx_data <= 8'h00;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= 8'h00;
            num_bytes   <= '0;
            nak_count   <= 8'h00;
            expected    <= 8'd1;
            blk_acc     <= '0;
            blk         <= 8'h00;
            csum        <= 8'h00;
            idx         <= '0;
            hdr_ok      <= 1'b0;
            dup         <= 1'b0;
            eot         <= 1'b0;
            tcnt        <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (timed) tcnt <= bus.rx_valid ? 32'd0 : tcnt + 32'd1;
            else       tcnt <= 32'd0;

            if (tmo) begin
                state       <= RESP;
                bus.tx_data <= NAK;
                eot         <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state       <= SEND_START_NAK;
                            bus.tx_data <= NAK;
                            num_bytes   <= '0;
                            nak_count   <= 8'h00;
                            blk_acc     <= '0;
                            expected    <= 8'd1;
                            eot         <= 1'b0;
                            tcnt        <= 32'd0;
                        end
                    end
                    SEND_START_NAK: begin
                        if (hs) begin
                            state     <= WAIT_SOH;
                            nak_count <= nak_count + 8'd1;
                        end
                    end
                    WAIT_SOH: begin
                        if (bus.rx_valid) begin
                            if (bus.rx_data == SOH) begin
                                state <= BLK;
                            end else if (bus.rx_data == EOT) begin
                                state       <= RESP;
                                bus.tx_data <= ACK;
                                eot         <= 1'b1;
                            end
                        end
                    end
                    BLK: begin
                        if (bus.rx_valid) begin
                            blk   <= bus.rx_data;
                            state <= BLK_INV;
                        end
                    end
                    BLK_INV: begin
                        if (bus.rx_valid) begin
                            hdr_ok <= (bus.rx_data == ~blk) &&
                                      ((blk == expected) || (blk == expected - 8'd1));
                            dup    <= (blk == expected - 8'd1);
                            idx    <= '0;
                            csum   <= 8'h00;
                            state  <= DATA;
                        end
                    end
                    DATA: begin
                        if (bus.rx_valid) begin
                            csum <= csum + bus.rx_data;
                            idx  <= idx + 1'b1;
                            if (hdr_ok) begin
                                bus.wr_en   <= 1'b1;
                                bus.wr_data <= bus.rx_data;
                                bus.wr_addr <= ADDR_W'({blk_sel, idx});
                            end
                            if (idx == IDX_W'(BLOCK_BYTES - 1)) state <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (bus.rx_valid) begin
                            if (hdr_ok && (bus.rx_data == csum)) begin
                                bus.tx_data <= ACK;
                                if (!dup) begin
                                    blk_acc   <= blk_acc + 1'b1;
                                    expected  <= expected + 8'd1;
                                    num_bytes <= num_bytes + (ADDR_W+1)'(BLOCK_BYTES);
                                end
                            end else begin
                                bus.tx_data <= NAK;
                            end
                            eot   <= 1'b0;
                            state <= RESP;
                        end
                    end
                    RESP: begin
                        if (hs) begin
                            if ((bus.tx_data == NAK) && (nak_count != 8'hFF))
                                nak_count <= nak_count + 8'd1;
                            state <= eot ? DONE : WAIT_SOH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_xmodem_rx_ctrl.sv
// tb/tb_xmodem_rx_ctrl.sv - directed and randomized bench for xmodem_rx_ctrl against a block-level model
module tb_xmodem_rx_ctrl;
    localparam int BB = 128;
    localparam int AW = 15;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [AW:0]   num_bytes;
    logic [7:0]    nak_count;

    xmodem_rx_ctrl_if #(.ADDR_W(AW)) bus();

    xmodem_rx_ctrl #(.BLOCK_BYTES(BB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .bus(bus),
        .busy(busy), .done(done), .num_bytes(num_bytes), .nak_count(nak_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] dut_mem [0:1023];
    logic [7:0] ref_mem [0:1023];
    int         wr_count = 0;

    always @(posedge clk) begin
        if (bus.wr_en) begin
            dut_mem[bus.wr_addr[9:0]] <= bus.wr_data;
            wr_count <= wr_count + 1;
        end
    end

    int ref_exp, ref_acc, ref_num, ref_nak, ref_wr, ref_top;
    logic [7:0] pl [BB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] psum();
        int s = 0;
        foreach (pl[i]) s += int'(pl[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp_b);
        int n = 0;
        while (!bus.tx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " tx_valid"}, 32'(bus.tx_valid), 32'd1);
        chk({tag, " tx_data"}, 32'(bus.tx_data), 32'(exp_b));
        if (bus.tx_valid) begin
            bus.tx_ready = 1'b1;
            @(negedge clk);
            bus.tx_ready = 1'b0;
        end
    endtask

    // Outcome of one whole frame, computed from the protocol rules
    task automatic model_block(input logic [7:0] b, input logic [7:0] inv, input logic [7:0] cs,
                               output logic [7:0] resp);
        logic [7:0] e;
        bit hdr, is_dup;
        int base;
        e      = 8'(ref_exp);
        hdr    = (inv == ~b) && ((b == e) || (b == e - 8'd1));
        is_dup = (b == e - 8'd1);
        if (hdr) begin
            base = is_dup ? ref_acc - 1 : ref_acc;
            for (int i = 0; i < BB; i++) ref_mem[base*BB + i] = pl[i];
            ref_wr += BB;
            if (base*BB + BB > ref_top) ref_top = base*BB + BB;
        end
        if (hdr && cs == psum()) begin
            resp = 8'h06;
            if (!is_dup) begin
                ref_acc++;
                ref_exp = (ref_exp + 1) % 256;
                ref_num += BB;
            end
        end else begin
            resp = 8'h15;
            if (ref_nak < 255) ref_nak++;
        end
    endtask

    task automatic run_block(input string tag, input logic [7:0] b, input logic [7:0] inv,
                             input logic [7:0] cs);
        logic [7:0] r;
        model_block(b, inv, cs, r);
        send_byte(8'h01);
        send_byte(b);
        send_byte(inv);
        for (int i = 0; i < BB; i++) send_byte(pl[i]);
        send_byte(cs);
        get_resp(tag, r);
        chk({tag, " num_bytes"}, 32'(num_bytes), 32'(ref_num));
        chk({tag, " nak_count"}, 32'(nak_count), 32'(ref_nak));
        chk({tag, " wr_count"}, 32'(wr_count), 32'(ref_wr));
    endtask

    task automatic fill_random();
        for (int i = 0; i < BB; i++) pl[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] b, inv, cs;
        int n, mism;

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        ref_exp = 1; ref_acc = 0; ref_num = 0; ref_nak = 0; ref_wr = 0; ref_top = 0;

        repeat (3) @(negedge clk);
        chk("reset tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("reset tx_data", 32'(bus.tx_data), 32'd0);
        chk("reset wr_en", 32'(bus.wr_en), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset num_bytes", 32'(num_bytes), 32'd0);
        chk("reset nak_count", 32'(nak_count), 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // start together with a byte: the byte must be ignored
        start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h01;
        @(negedge clk);
        start = 1'b0;
        bus.rx_valid = 1'b0;
        chk("start tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("start tx_data", 32'(bus.tx_data), 32'h15);
        chk("start busy", 32'(busy), 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        ref_nak = 1;
        chk("start nak_count", 32'(nak_count), 32'd1);
        chk("start tx_valid low", 32'(bus.tx_valid), 32'd0);

        for (int i = 0; i < BB; i++) pl[i] = 8'(i);
        run_block("blk1 bad csum", 8'h01, 8'hFE, 8'hBF);
        run_block("blk1 good", 8'h01, 8'hFE, 8'hC0);
        fill_random();
        run_block("blk1 dup", 8'h01, 8'hFE, psum());
        fill_random();
        run_block("bad hdr", 8'h02, 8'hFC, psum());
        fill_random();
        run_block("blk2", 8'h02, 8'hFD, psum());

        for (int k = 0; k < 4; k++) begin
            fill_random();
            case ($urandom % 4)
                0:       b = 8'(ref_exp);
                1:       b = (ref_acc > 0) ? 8'(ref_exp - 1) : 8'(ref_exp);
                2:       b = 8'(ref_exp + 1);
                default: b = 8'(ref_exp);
            endcase
            inv = (($urandom % 5) == 0) ? (~b ^ 8'h10) : ~b;
            cs  = psum() ^ ((($urandom % 4) == 0) ? 8'h01 : 8'h00);
            run_block("random blk", b, inv, cs);
        end

        // Stall mid-block: partial writes land, then a NAK after the idle limit
        fill_random();
        b = 8'(ref_exp);
        send_byte(8'h01);
        send_byte(b);
        send_byte(~b);
        for (int i = 0; i < 10; i++) send_byte(pl[i]);
        for (int i = 0; i < 10; i++) ref_mem[ref_acc*BB + i] = pl[i];
        ref_wr += 10;
        if (ref_nak < 255) ref_nak++;
        n = 0;
        while (!bus.tx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout tx_valid", 32'(bus.tx_valid), 32'd1);
        chk("timeout window", 32'(n >= TO - 5 && n <= TO + 2), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("timeout hold tx_data", 32'(bus.tx_data), 32'h15);
            @(negedge clk);
        end
        chk("timeout hold tx_valid", 32'(bus.tx_valid), 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        chk("timeout nak_count", 32'(nak_count), 32'(ref_nak));
        run_block("after timeout", b, ~b, psum());

        send_byte(8'h04);
        get_resp("eot", 8'h06);
        chk("eot done", 32'(done), 32'd1);
        chk("eot busy", 32'(busy), 32'd0);
        chk("eot num_bytes", 32'(num_bytes), 32'(ref_num));
        chk("eot wr_count", 32'(wr_count), 32'(ref_wr));
        mism = 0;
        for (int a = 0; a < ref_top; a++) if (dut_mem[a] !== ref_mem[a]) mism++;
        chk("memory image", 32'(mism), 32'd0);

        // Restart, accept one block, then reset while the NAK is pending
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart done", 32'(done), 32'd0);
        chk("restart num_bytes", 32'(num_bytes), 32'd0);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.tx_ready = 1'b0;
        ref_exp = 1; ref_acc = 0; ref_num = 0; ref_nak = 1; ref_wr = wr_count;
        fill_random();
        run_block("restart blk1", 8'h01, 8'hFE, psum());
        fill_random();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'hFD);
        for (int i = 0; i < BB; i++) send_byte(pl[i]);
        send_byte(psum() ^ 8'h80);
        chk("pre-reset tx_valid", 32'(bus.tx_valid), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("async reset tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("async reset tx_data", 32'(bus.tx_data), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset num_bytes", 32'(num_bytes), 32'd0);
        chk("async reset nak_count", 32'(nak_count), 32'd0);
        chk("async reset wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("async reset wr_en", 32'(bus.wr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
